// File: rtl/dev_io_hub.sv
// -----------------------------------------------------------------------------
// dev_io_hub
// Device I/O hub between the processor core and NCH external devices.
//   * Input side: each channel's enter_in level is synchronised (2 FF); a
//     rising edge of the synchronised level captures dev_in[c] into a
//     per-channel FIFO of DEPTH words. A capture into a full FIFO is dropped
//     and flags in_ovf[c] (sticky until the core issues a pop to channel c).
//   * Core read side: rd_req/rd_ch pops one word; the result appears one
//     cycle later as a rd_valid or rd_empty pulse.
//   * Output side: a per-channel four-phase handshake
//     (enter_out up, done_out up, enter_out down, done_out down) delivers a
//     word written by the core via wr_en/wr_ch/wr_data.
//   * Interrupt: irq is the registered OR of in_pending; irq_ch names the
//     first pending channel scanning upward from a round-robin pointer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   dev_in   [NCH*DW]   device input words, channel c at [c*DW +: DW]
//   enter_in [NCH]      device data-ready levels (asynchronous)
//   dev_out  [NCH*DW]   device output words, channel c at [c*DW +: DW]
//   enter_out[NCH]      registered output request per channel
//   done_out [NCH]      device acknowledge levels (asynchronous)
//   rd_req, rd_ch       pop request and channel
//   rd_data, rd_valid   popped word and its one-cycle valid pulse
//   rd_empty            one-cycle pulse: pop hit an empty/invalid channel
//   wr_en, wr_ch,       write request, channel and word
//   wr_data
//   wr_ack, wr_err      one-cycle accept / reject pulses
//   in_pending[NCH]     channel FIFO non-empty
//   in_ovf   [NCH]      sticky capture-overflow flags
//   out_busy [NCH]      output handshake in progress
//   irq, irq_ch         registered interrupt and selected channel
// -----------------------------------------------------------------------------
module dev_io_hub #(
   parameter  int NCH   = 4,
   parameter  int DW    = 32,
   parameter  int DEPTH = 4,
   localparam int CHW   = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*DW-1:0] dev_in,
   input  logic [NCH-1:0]    enter_in,
   output logic [NCH*DW-1:0] dev_out,
   output logic [NCH-1:0]    enter_out,
   input  logic [NCH-1:0]    done_out,
   input  logic              rd_req,
   input  logic [CHW-1:0]    rd_ch,
   output logic [DW-1:0]     rd_data,
   output logic              rd_valid,
   output logic              rd_empty,
   input  logic              wr_en,
   input  logic [CHW-1:0]    wr_ch,
   input  logic [DW-1:0]     wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [NCH-1:0]    in_pending,
   output logic [NCH-1:0]    in_ovf,
   output logic [NCH-1:0]    out_busy,
   output logic              irq,
   output logic [CHW-1:0]    irq_ch
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      O_IDLE    = 2'd0,
      O_DRIVE   = 2'd1,
      O_RELEASE = 2'd2
   } out_state_t;

   // Synchronisers: *_s2 is the first safe copy, in_s3 is its previous value
   // so that a capture is exactly one cycle wide per rising edge.
   logic [NCH-1:0] in_s1, in_s2, in_s3;
   logic [NCH-1:0] done_s1, done_s2;

   logic [DW-1:0]  mem    [NCH][DEPTH];
   logic [PW-1:0]  wr_ptr [NCH];
   logic [PW-1:0]  rd_ptr [NCH];
   logic [CW-1:0]  count  [NCH];

   logic [NCH-1:0] capture, full, pop_hit, pop_ok, push_ok, ovf_set;
   logic [NCH-1:0] wr_hit, idle;
   logic           pop_any, wr_ok;
   logic [DW-1:0]  head;

   logic [CHW-1:0] rr_ptr, rr_next;
   logic [CHW-1:0] sel_hi, sel_lo, sel_ch;
   logic           hi_found;

   out_state_t     ost [NCH];

   // ---------------------------------------------------------------------------
   // Per-channel FIFO control decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned (which would infer a latch).
      capture    = in_s2 & ~in_s3;
      full       = '0;
      pop_hit    = '0;
      pop_ok     = '0;
      push_ok    = '0;
      ovf_set    = '0;
      in_pending = '0;
      head       = '0;
      for (int c = 0; c < NCH; c++) begin
         in_pending[c] = (count[c] != '0);
         full[c]       = (count[c] == CW'(DEPTH));
         // Emptiness is judged on the count before this cycle's push.
         pop_hit[c]    = rd_req && (rd_ch == CHW'(c));
         pop_ok[c]     = pop_hit[c] && in_pending[c];
         // A simultaneous pop frees a slot, so a full FIFO still accepts.
         push_ok[c]    = capture[c] && (!full[c] || pop_ok[c]);
         ovf_set[c]    = capture[c] && full[c] && !pop_ok[c];
         if (pop_ok[c]) head = mem[c][rd_ptr[c]];
      end
      pop_any = |pop_ok;
   end

   // ---------------------------------------------------------------------------
   // Round-robin select: lowest pending channel at or above rr_ptr, otherwise
   // lowest pending channel below it (wrap). Zero when nothing is pending.
   // ---------------------------------------------------------------------------
   always_comb begin
      sel_hi   = '0;
      sel_lo   = '0;
      hi_found = 1'b0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (in_pending[c]) begin
            if (CHW'(c) >= rr_ptr) begin
               sel_hi   = CHW'(c);
               hi_found = 1'b1;
            end else begin
               sel_lo = CHW'(c);
            end
         end
      end
      sel_ch  = hi_found ? sel_hi : sel_lo;
      rr_next = (irq_ch == CHW'(NCH - 1)) ? '0 : irq_ch + CHW'(1);
   end

   // ---------------------------------------------------------------------------
   // Input synchronisers, FIFO pointers, pop results, interrupt
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_s1    <= '0;
         in_s2    <= '0;
         in_s3    <= '0;
         in_ovf   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_empty <= 1'b0;
         irq      <= 1'b0;
         irq_ch   <= '0;
         rr_ptr   <= '0;
         for (int c = 0; c < NCH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            count[c]  <= '0;
         end
      end else begin
         // NOTE: state updates use non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         in_s1    <= enter_in;
         in_s2    <= in_s1;
         in_s3    <= in_s2;
         rd_valid <= rd_req && pop_any;
         rd_empty <= rd_req && !pop_any;
         rd_data  <= pop_any ? head : '0;
         irq      <= |in_pending;
         irq_ch   <= sel_ch;
         if (pop_any && (rd_ch == irq_ch)) rr_ptr <= rr_next;

         for (int c = 0; c < NCH; c++) begin
            if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
            if (pop_ok[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
            case ({push_ok[c], pop_ok[c]})
               2'b10:   count[c] <= count[c] + CW'(1);
               2'b01:   count[c] <= count[c] - CW'(1);
               default: count[c] <= count[c];
            endcase
            if (ovf_set[c])      in_ovf[c] <= 1'b1;
            else if (pop_hit[c]) in_ovf[c] <= 1'b0;
         end
      end
   end

   // NOTE: FIFO storage carries no reset; validity is tracked by the pointers
   // and counts, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (push_ok[c]) mem[c][wr_ptr[c]] <= dev_in[c*DW +: DW];
      end
   end

   // ---------------------------------------------------------------------------
   // Output handshake FSMs
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_hit = '0;
      idle   = '0;
      for (int c = 0; c < NCH; c++) begin
         wr_hit[c] = wr_en && (wr_ch == CHW'(c));
         idle[c]   = (ost[c] == O_IDLE);
      end
      out_busy = ~idle;
      wr_ok    = |(wr_hit & idle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_s1   <= '0;
         done_s2   <= '0;
         enter_out <= '0;
         dev_out   <= '0;
         wr_ack    <= 1'b0;
         wr_err    <= 1'b0;
         for (int c = 0; c < NCH; c++) ost[c] <= O_IDLE;
      end else begin
         done_s1 <= done_out;
         done_s2 <= done_s1;
         wr_ack  <= wr_ok;
         wr_err  <= wr_en && !wr_ok;
         for (int c = 0; c < NCH; c++) begin
            case (ost[c])
               O_IDLE: begin
                  if (wr_hit[c]) begin
                     dev_out[c*DW +: DW] <= wr_data;
                     enter_out[c]        <= 1'b1;
                     ost[c]              <= O_DRIVE;
                  end
               end
               O_DRIVE: begin
                  if (done_s2[c]) begin
                     enter_out[c] <= 1'b0;
                     ost[c]       <= O_RELEASE;
                  end
               end
               O_RELEASE: begin
                  if (!done_s2[c]) ost[c] <= O_IDLE;
               end
               default: begin
                  enter_out[c] <= 1'b0;
                  ost[c]       <= O_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dev_io_hub.sv
// -----------------------------------------------------------------------------
// tb_dev_io_hub
// Directed bench for dev_io_hub (NCH=4, DW=32, DEPTH=4). Inputs are driven
// and outputs sampled on the falling clock edge; all expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dev_io_hub;

   localparam int NCH   = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic [NCH*DW-1:0] dev_in   = '0;
   logic [NCH-1:0]    enter_in = '0;
   logic [NCH*DW-1:0] dev_out;
   logic [NCH-1:0]    enter_out;
   logic [NCH-1:0]    done_out = '0;
   logic              rd_req   = 1'b0;
   logic [1:0]        rd_ch    = '0;
   logic [DW-1:0]     rd_data;
   logic              rd_valid, rd_empty;
   logic              wr_en    = 1'b0;
   logic [1:0]        wr_ch    = '0;
   logic [DW-1:0]     wr_data  = '0;
   logic              wr_ack, wr_err;
   logic [NCH-1:0]    in_pending, in_ovf, out_busy;
   logic              irq;
   logic [1:0]        irq_ch;

   int n_vec = 0;
   int n_err = 0;

   dev_io_hub #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dev_in    (dev_in),
      .enter_in  (enter_in),
      .dev_out   (dev_out),
      .enter_out (enter_out),
      .done_out  (done_out),
      .rd_req    (rd_req),
      .rd_ch     (rd_ch),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_empty  (rd_empty),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .wr_err    (wr_err),
      .in_pending(in_pending),
      .in_ovf    (in_ovf),
      .out_busy  (out_busy),
      .irq       (irq),
      .irq_ch    (irq_ch)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before 1000000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One complete capture: raise enter_in long enough to be pushed, drop it,
   // and let the synchroniser return low before the next capture.
   task automatic capture(input int ch, input logic [DW-1:0] data);
      dev_in[ch*DW +: DW] = data;
      enter_in[ch] = 1'b1;
      cyc(3);
      enter_in[ch] = 1'b0;
      cyc(2);
   endtask

   task automatic pop(input string tag, input int ch, input logic exp_valid,
                      input logic [DW-1:0] exp_data);
      rd_req = 1'b1;
      rd_ch  = 2'(ch);
      cyc(1);
      rd_req = 1'b0;
      check({tag, ".valid"}, rd_valid, exp_valid);
      check({tag, ".empty"}, rd_empty, !exp_valid);
      check({tag, ".data"},  rd_data,  exp_data);
   endtask

   task automatic wr(input int ch, input logic [DW-1:0] data);
      wr_en   = 1'b1;
      wr_ch   = 2'(ch);
      wr_data = data;
      cyc(1);
      wr_en   = 1'b0;
   endtask

   initial begin
      // ---- reset state ----
      cyc(2);
      check("rst.flags",   {rd_valid, rd_empty, wr_ack, wr_err, irq}, 0);
      check("rst.pending", in_pending, 0);
      check("rst.ovf",     in_ovf, 0);
      check("rst.busy",    out_busy, 0);
      check("rst.enter",   enter_out, 0);
      check("rst.dev_out", dev_out, 0);
      check("rst.irq_ch",  irq_ch, 0);
      rst_n = 1'b1;
      cyc(1);

      // ---- single capture on ch2: latency and irq ----
      dev_in[2*DW +: DW] = 32'hCAFE_0002;
      enter_in[2] = 1'b1;
      cyc(2);
      check("cap.lat2", in_pending, 4'b0000);
      cyc(1);
      check("cap.lat3", in_pending, 4'b0100);
      check("cap.irq_reg", irq, 0);
      enter_in[2] = 1'b0;
      cyc(1);
      check("cap.irq", irq, 1);
      check("cap.irq_ch", irq_ch, 2);
      cyc(1);
      pop("cap.pop", 2, 1'b1, 32'hCAFE_0002);
      check("cap.drained", in_pending, 0);
      cyc(1);
      check("cap.irq_off", irq, 0);

      // ---- overflow on ch1, in-order pops, pop when empty ----
      for (int i = 0; i < 5; i++) begin
         capture(1, 32'h1111_0000 + i);
         if (i == 3) check("ovf.before", in_ovf, 0);
      end
      check("ovf.set",  in_ovf, 4'b0010);
      check("ovf.pend", in_pending, 4'b0010);
      for (int i = 0; i < 4; i++) begin
         pop("ovf.pop", 1, 1'b1, 32'h1111_0000 + i);
         if (i == 0) check("ovf.clr", in_ovf, 0);
      end
      pop("ovf.empty", 1, 1'b0, 32'h0);

      // ---- empty + push + pop in the same cycle on ch0 ----
      dev_in[0 +: DW] = 32'h0BAD_0000;
      enter_in[0] = 1'b1;
      cyc(2);
      rd_req = 1'b1;
      rd_ch  = 2'd0;
      cyc(1);
      rd_req = 1'b0;
      enter_in[0] = 1'b0;
      check("epp.empty", rd_empty, 1);
      check("epp.valid", rd_valid, 0);
      check("epp.pend",  in_pending, 4'b0001);
      cyc(2);
      pop("epp.pop", 0, 1'b1, 32'h0BAD_0000);

      // ---- full + push + pop in the same cycle on ch3 ----
      for (int i = 0; i < 4; i++) capture(3, 32'h3333_0000 + i);
      dev_in[3*DW +: DW] = 32'h3333_0004;
      enter_in[3] = 1'b1;
      cyc(2);
      rd_req = 1'b1;
      rd_ch  = 2'd3;
      cyc(1);
      rd_req = 1'b0;
      enter_in[3] = 1'b0;
      check("fpp.valid", rd_valid, 1);
      check("fpp.data",  rd_data, 32'h3333_0000);
      check("fpp.ovf",   in_ovf, 0);
      cyc(2);
      for (int i = 1; i <= 4; i++) pop("fpp.pop", 3, 1'b1, 32'h3333_0000 + i);
      check("fpp.drained", in_pending, 0);

      // ---- round-robin irq_ch ----
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      capture(0, 32'h0000_00A0);
      capture(3, 32'h0000_00D3);
      check("rr.irq",  irq, 1);
      check("rr.ch_a", irq_ch, 0);
      pop("rr.pop0", 0, 1'b1, 32'h0000_00A0);
      cyc(1);
      check("rr.ch_b", irq_ch, 3);
      capture(0, 32'h0000_00A1);
      check("rr.ch_c", irq_ch, 3);
      pop("rr.pop3", 3, 1'b1, 32'h0000_00D3);
      cyc(1);
      check("rr.ch_d", irq_ch, 0);
      check("rr.irq2", irq, 1);
      pop("rr.drain", 0, 1'b1, 32'h0000_00A1);

      // ---- output handshake on ch1 ----
      wr(1, 32'h1234_5678);
      check("hs.ack",     wr_ack, 1);
      check("hs.err",     wr_err, 0);
      check("hs.enter",   enter_out, 4'b0010);
      check("hs.busy",    out_busy, 4'b0010);
      check("hs.dev_out", dev_out[1*DW +: DW], 32'h1234_5678);
      done_out[1] = 1'b1;
      cyc(2);
      check("hs.hold", enter_out, 4'b0010);
      cyc(1);
      check("hs.drop", enter_out, 4'b0000);
      check("hs.busy_rel", out_busy, 4'b0010);
      wr(1, 32'hAAAA_5555);
      check("hs.rel_err", wr_err, 1);
      check("hs.rel_ack", wr_ack, 0);
      check("hs.rel_out", dev_out[1*DW +: DW], 32'h1234_5678);
      done_out[1] = 1'b0;
      cyc(2);
      check("hs.busy_wait", out_busy, 4'b0010);
      cyc(1);
      check("hs.idle", out_busy, 4'b0000);
      check("hs.kept", dev_out[1*DW +: DW], 32'h1234_5678);
      wr(1, 32'h0F0F_0F0F);
      check("hs.re_ack",   wr_ack, 1);
      check("hs.re_enter", enter_out, 4'b0010);
      check("hs.re_out",   dev_out[1*DW +: DW], 32'h0F0F_0F0F);

      // ---- reset in the middle of a ch3 handshake ----
      capture(2, 32'h0000_0022);
      wr(3, 32'h0000_0033);
      check("mid.enter", enter_out, 4'b1010);
      check("mid.pend",  in_pending, 4'b0100);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid.enter0", enter_out, 0);
      check("mid.out0",   dev_out, 0);
      check("mid.pend0",  in_pending, 0);
      check("mid.busy0",  out_busy, 0);
      check("mid.flags0", {rd_valid, rd_empty, wr_ack, wr_err, irq}, 0);
      check("mid.ch0",    irq_ch, 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      check("mid.after", {enter_out, in_pending, out_busy}, 0);
      check("mid.no_ack", wr_ack, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
